// File: rtl/lsu_pkg.sv
// Shared LSU types: funct3 size codes, FSM states, width classes.
package lsu_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam logic [31:0] LSU_TIMEOUT_DATA = 32'hdead_beef;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  typedef enum logic [1:0] {
    W_BYTE,
    W_HALF,
    W_WORD
  } width_e;

  // Unlisted size codes fall into the word class.
  function automatic width_e width_of(logic [2:0] s);
    width_e w;
    w = W_WORD;
    unique case (1'b1)
      (s == SZ_B) || (s == SZ_BU): w = W_BYTE;
      (s == SZ_H) || (s == SZ_HU): w = W_HALF;
      default:                     w = W_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load lane select and sign/zero extension of a memory word.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sgn;

  always_comb begin
    b    = word[{off, 3'b000} +: 8];
    h    = off[1] ? word[31:16] : word[15:0];
    sgn  = ~size[2];
    data = word;
    unique case (width_of(size))
      W_BYTE:  data = {{24{sgn & b[7]}}, b};
      W_HALF:  data = {{16{sgn & h[15]}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit with wait timeout.
// Optional misaligned trap: define LSU_MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e      state;
  logic [CW-1:0] cnt;
  logic [31:0] rd_q;
  logic [31:0] ext;
  logic [31:0] rd_now;
  width_e      wid;
  logic        legal;
  logic        idle;
  logic        busy;
  logic        timeout;
  logic        done;
  logic        issue;

  lsu_load_ext u_ext (
    .word (mem_rd_i),
    .off  (core_addr_i[1:0]),
    .size (core_size_i),
    .data (ext)
  );

  always_comb begin
    wid = width_of(core_size_i);
`ifdef LSU_MISALIGN_TRAP_EN
    legal = !(((wid == W_HALF) && core_addr_i[0]) ||
              ((wid == W_WORD) && (core_addr_i[1:0] != 2'b00)));
`else
    legal = 1'b1;
`endif
    // Reset gates the outputs so they fall without waiting for a clock.
    idle    = rst_ni & (state == S_IDLE);
    busy    = rst_ni & (state == S_BUSY);
    timeout = busy & ~mem_ready_i & (cnt == CW'(MAX_WAIT));
    done    = busy & (mem_ready_i | timeout);
    issue   = idle & core_req_i & legal;

    mem_req_o    = issue | busy;
    mem_we_o     = mem_req_o & core_we_i;
    core_stall_o = rst_ni & core_req_i & ~done
                 & ~(idle & ~legal);
    err_o        = timeout | (idle & core_req_i & ~legal);

    rd_now    = timeout ? LSU_TIMEOUT_DATA : ext;
    core_rd_o = done ? rd_now : rd_q;

    mem_addr_o = {core_addr_i[31:2], 2'b00};
    mem_be_o   = 4'b0000;
    mem_wd_o   = core_wd_i;
    unique case (wid)
      W_BYTE: begin
        mem_wd_o = {4{core_wd_i[7:0]}};
        if (core_we_i) mem_be_o = 4'b0001 << core_addr_i[1:0];
      end
      W_HALF: begin
        mem_wd_o = {2{core_wd_i[15:0]}};
        if (core_we_i) mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
      end
      default: begin
        mem_wd_o = core_wd_i;
        if (core_we_i) mem_be_o = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      cnt   <= '0;
      rd_q  <= '0;
    end else begin
      if (issue) begin
        state <= S_BUSY;
        cnt   <= '0;
      end else if (done) begin
        state <= S_IDLE;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
      end
      if (done) rd_q <= rd_now;
    end
  end

endmodule
